// File: rtl/dmem_mmio_pkg.sv
// dmem_mmio_pkg: address decode constants, MMIO register word offsets and STATUS bit positions
package dmem_mmio_pkg;
  localparam logic [23:0] MMIO_BASE = 24'h10_0000;
  localparam logic [3:0] RAM_REGION = 4'h0;
  localparam logic [5:0] OFF_TXDATA = 6'h0;
  localparam logic [5:0] OFF_STATUS = 6'h1;
  localparam logic [5:0] OFF_CYCLE_LO = 6'h2;
  localparam logic [5:0] OFF_CYCLE_HI = 6'h3;
  localparam logic [5:0] OFF_SCRATCH = 6'h4;
  localparam int ST_FULL = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_OVF = 2;
  localparam int ST_CNT_LSB = 8;
endpackage

// File: rtl/dmem_mmio_sync_fifo.sv
// sync_fifo: circular-buffer FIFO; push/din in, pop in, full/empty/count/head out, push_ok flags an accepted push (full+pop accepts)
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  output logic                     empty,
  output logic                     push_ok,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic do_pop;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign do_pop = pop && !empty;
  assign push_ok = push && (!full || do_pop);
  assign head = mem[rd];
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr] <= din;
    if (rst) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (push_ok) wr <= wr + AW'(1);
      if (do_pop) rd <= rd + AW'(1);
      count <= count + CW'(push_ok) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/dmem_mmio.sv
// dmem_mmio: data-port responder (word RAM + MMIO: TX FIFO, 64-bit cycle counter, scratch); clock/reset, mem_load/mem_store/address/store_data -> load_data, tx_valid/tx_data/tx_ready stream, tx_overflow
module dmem_mmio
  import dmem_mmio_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RAM_AW = 12,
  parameter int TX_DEPTH = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            mem_load,
  input  logic            mem_store,
  input  logic [XLEN-1:0] address,
  input  logic [XLEN-1:0] store_data,
  output logic [XLEN-1:0] load_data,
  output logic            tx_valid,
  output logic [7:0]      tx_data,
  input  logic            tx_ready,
  output logic            tx_overflow
);
  localparam int CW = $clog2(TX_DEPTH) + 1;
  logic [XLEN-1:0] ram [2**RAM_AW];
  logic [63:0] cnt;
  logic [XLEN-1:0] hi_snap, scratch, status, mmio_rd;
  logic overflow, ram_sel, mmio_sel, full, empty, push_req, push_ok, pop, clr_ovf, unused_ok;
  logic [5:0] off;
  logic [RAM_AW-1:0] ram_idx;
  logic [CW-1:0] count;
  logic [31:0] count_ext;
  assign ram_sel = address[31:28] == RAM_REGION;
  assign mmio_sel = address[31:8] == MMIO_BASE;
  assign off = address[7:2];
  assign ram_idx = address[RAM_AW+1:2];
  assign pop = tx_valid && tx_ready;
  assign push_req = mem_store && mmio_sel && off == OFF_TXDATA && !reset;
  assign clr_ovf = mem_store && mmio_sel && off == OFF_STATUS && store_data[ST_OVF];
  assign count_ext = 32'(count);
  assign tx_valid = !empty;
  assign tx_overflow = overflow;
  assign unused_ok = &{1'b0, address[1:0]};
  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx (
    .clk(clock),
    .rst(reset),
    .push(push_req),
    .pop(pop),
    .din(store_data[7:0]),
    .full(full),
    .empty(empty),
    .push_ok(push_ok),
    .count(count),
    .head(tx_data)
  );
  always_comb begin
    status = '0;
    status[ST_FULL] = full;
    status[ST_EMPTY] = empty;
    status[ST_OVF] = overflow;
    status[ST_CNT_LSB +: 4] = count_ext > 32'd15 ? 4'hf : count_ext[3:0];
  end
  assign mmio_rd = off == OFF_STATUS   ? status :
                   off == OFF_CYCLE_LO ? cnt[XLEN-1:0] :
                   off == OFF_CYCLE_HI ? hi_snap :
                   off == OFF_SCRATCH  ? scratch : '0;
  assign load_data = ram_sel ? ram[ram_idx] : mmio_sel ? mmio_rd : '0;
  // RAM has no reset: stores commit even during reset
  always_ff @(posedge clock) begin
    if (mem_store && ram_sel) ram[ram_idx] <= store_data;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
      hi_snap <= '0;
      scratch <= '0;
      overflow <= 1'b0;
    end else begin
      cnt <= cnt + 64'd1;
      if (mem_load && mmio_sel && off == OFF_CYCLE_LO) hi_snap <= cnt[63:32];
      if (mem_store && mmio_sel && off == OFF_SCRATCH) scratch <= store_data;
      overflow <= (push_req && !push_ok) || (overflow && !clr_ovf);
    end
  end
endmodule

// File: tb/tb_dmem_mmio.sv
// tb_dmem_mmio: directed and randomized checks of dmem_mmio against a queue/array reference model
module tb_dmem_mmio;
  localparam int DEPTH = 8;
  localparam logic [31:0] TX_A = 32'h1000_0000;
  localparam logic [31:0] ST_A = 32'h1000_0004;
  localparam logic [31:0] LO_A = 32'h1000_0008;
  localparam logic [31:0] HI_A = 32'h1000_000C;
  localparam logic [31:0] SC_A = 32'h1000_0010;
  logic clock = 1'b0, reset, mem_load, mem_store, tx_valid, tx_ready, tx_overflow;
  logic [31:0] address, store_data, load_data;
  logic [7:0] tx_data;
  int checks = 0, errors = 0;
  logic [31:0] ram_m [int];
  logic [7:0] q_m [$];
  logic [63:0] cnt_m;
  logic [31:0] hi_m, scr_m;
  logic ovf_m;
  dmem_mmio dut (
    .clock(clock), .reset(reset), .mem_load(mem_load), .mem_store(mem_store),
    .address(address), .store_data(store_data), .load_data(load_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .tx_overflow(tx_overflow)
  );
  always #5 clock = ~clock;
  function automatic logic [31:0] model_rd(input logic [31:0] a);
    int n;
    if (a[31:28] == 4'h0) return ram_m.exists(int'(a[13:2])) ? ram_m[int'(a[13:2])] : 32'h0;
    if (a[31:8] != 24'h10_0000) return 32'h0;
    n = q_m.size() > 15 ? 15 : q_m.size();
    case (a[7:2])
      6'h1: return {20'h0, 4'(n), 5'h0, ovf_m, q_m.size() == 0, q_m.size() == DEPTH};
      6'h2: return cnt_m[31:0];
      6'h3: return hi_m;
      6'h4: return scr_m;
      default: return 32'h0;
    endcase
  endfunction
  task automatic model_edge();
    logic mm, popped;
    logic [5:0] off;
    if (mem_store && address[31:28] == 4'h0) ram_m[int'(address[13:2])] = store_data;
    if (reset) begin
      q_m.delete();
      cnt_m = 0;
      hi_m = 0;
      scr_m = 0;
      ovf_m = 0;
      return;
    end
    mm = address[31:8] == 24'h10_0000;
    off = address[7:2];
    popped = q_m.size() != 0 && tx_ready;
    if (mem_load && mm && off == 6'h2) hi_m = cnt_m[63:32];
    if (mem_store && mm && off == 6'h1 && store_data[2]) ovf_m = 0;
    if (mem_store && mm && off == 6'h4) scr_m = store_data;
    if (popped) void'(q_m.pop_front());
    if (mem_store && mm && off == 6'h0) begin
      if (q_m.size() < DEPTH) q_m.push_back(store_data[7:0]);
      else ovf_m = 1;
    end
    cnt_m += 64'd1;
  endtask
  task automatic drive(input logic ld, st, input logic [31:0] a, d, input logic rdy, rs);
    mem_load = ld;
    mem_store = st;
    address = a;
    store_data = d;
    tx_ready = rdy;
    reset = rs;
    @(negedge clock);
  endtask
  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
  endtask
  task automatic test_reset();
    drive(1, 0, ST_A, 0, 0, 0);
    checks++; if (load_data !== 32'h2) begin errors++; $display("FAIL reset_status: got %h expected %h", load_data, 32'h2); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
    checks++; if (tx_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", tx_overflow); end
    tick();
    drive(1, 0, SC_A, 0, 0, 0);
    checks++; if (load_data !== 32'h0) begin errors++; $display("FAIL reset_scratch: got %h expected 0", load_data); end
    tick();
    drive(1, 0, HI_A, 0, 0, 0);
    checks++; if (load_data !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected 0", load_data); end
    tick();
  endtask
  task automatic test_ram();
    drive(0, 1, 32'h40, 32'hDEADBEEF, 0, 0);
    tick();
    drive(1, 0, 32'h40, 0, 0, 0);
    checks++; if (load_data !== 32'hDEADBEEF) begin errors++; $display("FAIL ram_word: got %h expected %h", load_data, 32'hDEADBEEF); end
    tick();
    drive(1, 0, 32'h41, 0, 0, 0);
    checks++; if (load_data !== 32'hDEADBEEF) begin errors++; $display("FAIL ram_byte_offset: got %h expected %h", load_data, 32'hDEADBEEF); end
    tick();
    drive(1, 1, 32'h40, 32'h11111111, 0, 0);
    checks++; if (load_data !== 32'hDEADBEEF) begin errors++; $display("FAIL ram_read_during_write: got %h expected %h", load_data, 32'hDEADBEEF); end
    tick();
    drive(1, 0, 32'h0FFF_C040, 0, 0, 0);
    checks++; if (load_data !== 32'h11111111) begin errors++; $display("FAIL ram_mirror: got %h expected %h", load_data, 32'h11111111); end
    tick();
  endtask
  task automatic test_tx();
    drive(0, 1, TX_A, 32'h41, 0, 0);
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_no_bypass: got %b expected 0", tx_valid); end
    tick();
    drive(0, 1, TX_A, 32'h42, 0, 0);
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin errors++; $display("FAIL tx_first: got v=%b d=%h expected v=1 d=41", tx_valid, tx_data); end
    tick();
    drive(0, 1, TX_A, 32'h43, 0, 0);
    tick();
    drive(1, 0, ST_A, 0, 0, 0);
    checks++; if (load_data !== 32'h300) begin errors++; $display("FAIL tx_status3: got %h expected %h", load_data, 32'h300); end
    checks++; if (tx_data !== 8'h41) begin errors++; $display("FAIL tx_hold: got %h expected 41", tx_data); end
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 32'h0, 0, 1, 0);
      checks++; if (tx_valid !== 1'b1 || tx_data !== 8'(8'h41 + i)) begin errors++; $display("FAIL tx_drain%0d: got v=%b d=%h expected v=1 d=%h", i, tx_valid, tx_data, 8'(8'h41 + i)); end
      tick();
    end
    drive(1, 0, ST_A, 0, 0, 0);
    checks++; if (tx_valid !== 1'b0 || load_data !== 32'h2) begin errors++; $display("FAIL tx_empty: got v=%b status=%h expected v=0 status=2", tx_valid, load_data); end
    tick();
  endtask
  task automatic test_overflow();
    for (int i = 0; i < 9; i++) begin
      drive(0, 1, TX_A, 32'h50 + i, 0, 0);
      tick();
    end
    drive(1, 0, ST_A, 0, 0, 0);
    checks++; if (load_data !== 32'h805) begin errors++; $display("FAIL ovf_status: got %h expected %h", load_data, 32'h805); end
    checks++; if (tx_overflow !== 1'b1 || tx_data !== 8'h50) begin errors++; $display("FAIL ovf_flag: got ovf=%b d=%h expected ovf=1 d=50", tx_overflow, tx_data); end
    tick();
    drive(0, 1, ST_A, 32'hFFFF_FFFB, 0, 0);
    tick();
    drive(1, 0, ST_A, 0, 0, 0);
    checks++; if (tx_overflow !== 1'b1) begin errors++; $display("FAIL ovf_no_clear: got %b expected 1", tx_overflow); end
    tick();
    drive(0, 1, ST_A, 32'h4, 0, 0);
    tick();
    drive(1, 0, ST_A, 0, 0, 0);
    checks++; if (load_data !== 32'h801 || tx_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %h/%b expected 801/0", load_data, tx_overflow); end
    tick();
    drive(0, 1, TX_A, 32'h99, 1, 0);
    tick();
    drive(1, 0, ST_A, 0, 0, 0);
    checks++; if (load_data !== 32'h801 || tx_data !== 8'h51) begin errors++; $display("FAIL full_push_pop: got %h d=%h expected 801 d=51", load_data, tx_data); end
    tick();
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 32'h0, 0, 1, 0);
      checks++; if (tx_data !== (i == 7 ? 8'h99 : 8'(8'h51 + i))) begin errors++; $display("FAIL ovf_drain%0d: got %h expected %h", i, tx_data, (i == 7 ? 8'h99 : 8'(8'h51 + i))); end
      tick();
    end
    drive(1, 0, ST_A, 0, 0, 0);
    checks++; if (load_data !== 32'h2) begin errors++; $display("FAIL ovf_final: got %h expected 2", load_data); end
    tick();
  endtask
  task automatic test_counter();
    drive(0, 0, 32'h0, 0, 0, 1);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 32'h0, 0, 0, 0);
      tick();
    end
    drive(1, 0, LO_A, 0, 0, 0);
    checks++; if (load_data !== 32'd5) begin errors++; $display("FAIL cnt_lo: got %0d expected 5", load_data); end
    tick();
    drive(1, 0, HI_A, 0, 0, 0);
    checks++; if (load_data !== 32'd0) begin errors++; $display("FAIL cnt_hi: got %h expected 0", load_data); end
    tick();
    drive(1, 1, LO_A, 32'hFFFF_FFFF, 0, 0);
    checks++; if (load_data !== 32'd7) begin errors++; $display("FAIL cnt_lo2: got %0d expected 7", load_data); end
    tick();
    drive(1, 0, LO_A, 0, 0, 0);
    checks++; if (load_data !== 32'd8) begin errors++; $display("FAIL cnt_write_ignored: got %0d expected 8", load_data); end
    tick();
  endtask
  task automatic test_isolation();
    drive(0, 1, SC_A, 32'h12345678, 0, 0);
    tick();
    drive(1, 0, SC_A, 0, 0, 0);
    checks++; if (load_data !== 32'h12345678) begin errors++; $display("FAIL scratch: got %h expected %h", load_data, 32'h12345678); end
    tick();
    drive(1, 0, HI_A, 0, 0, 0);
    checks++; if (load_data !== 32'h0) begin errors++; $display("FAIL hi_isolated: got %h expected 0", load_data); end
    tick();
    drive(0, 1, 32'h2000_0040, 32'hCAFEF00D, 0, 0);
    tick();
    drive(1, 0, 32'h2000_0040, 0, 0, 0);
    checks++; if (load_data !== 32'h0) begin errors++; $display("FAIL unmapped_read: got %h expected 0", load_data); end
    tick();
    drive(1, 0, 32'h40, 0, 0, 0);
    checks++; if (load_data !== 32'h11111111) begin errors++; $display("FAIL unmapped_write: got %h expected %h", load_data, 32'h11111111); end
    tick();
    drive(1, 0, 32'h1000_0110, 0, 0, 0);
    checks++; if (load_data !== 32'h0) begin errors++; $display("FAIL mmio_page_edge: got %h expected 0", load_data); end
    tick();
  endtask
  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, TX_A, 32'h60 + i, 0, 0);
      tick();
    end
    drive(0, 1, 32'h80, 32'h5A5A5A5A, 0, 1);
    tick();
    drive(1, 0, ST_A, 0, 0, 0);
    checks++; if (tx_valid !== 1'b0 || load_data !== 32'h2) begin errors++; $display("FAIL rst_mid_fifo: got v=%b status=%h expected v=0 status=2", tx_valid, load_data); end
    tick();
    drive(1, 0, SC_A, 0, 0, 0);
    checks++; if (load_data !== 32'h0) begin errors++; $display("FAIL rst_mid_scratch: got %h expected 0", load_data); end
    tick();
    drive(0, 1, SC_A, 32'hFFFF, 0, 1);
    tick();
    drive(1, 0, SC_A, 0, 0, 0);
    checks++; if (load_data !== 32'h0) begin errors++; $display("FAIL rst_store_ignored: got %h expected 0", load_data); end
    tick();
    drive(1, 0, 32'h80, 0, 0, 0);
    checks++; if (load_data !== 32'h5A5A5A5A) begin errors++; $display("FAIL rst_ram_commit: got %h expected %h", load_data, 32'h5A5A5A5A); end
    tick();
    drive(1, 0, 32'h40, 0, 0, 0);
    checks++; if (load_data !== 32'h11111111) begin errors++; $display("FAIL rst_ram_kept: got %h expected %h", load_data, 32'h11111111); end
    tick();
  endtask
  task automatic test_random();
    logic [31:0] a, exp;
    int pick;
    for (int i = 0; i < 400; i++) begin
      pick = $urandom_range(0, 9);
      a = pick < 4 ? 32'h100 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3) :
          pick < 9 ? TX_A + ($urandom_range(0, 5) << 2) : (32'h3000_0000 | ($urandom & 32'h0FFF_FFFF));
      drive(1'($urandom_range(0, 1)), $urandom_range(0, 2) != 0, a, $urandom, $urandom_range(0, 2) == 0, 0);
      exp = model_rd(a);
      if (!(a[31:28] == 4'h0 && !ram_m.exists(int'(a[13:2])))) begin
        checks++; if (load_data !== exp) begin errors++; $display("FAIL rnd_load %0d @%h: got %h expected %h", i, a, load_data, exp); end
      end
      checks++; if (tx_valid !== (q_m.size() != 0) || tx_overflow !== ovf_m) begin errors++; $display("FAIL rnd_flags %0d: got v=%b o=%b expected v=%b o=%b", i, tx_valid, tx_overflow, q_m.size() != 0, ovf_m); end
      if (q_m.size() != 0) begin
        checks++; if (tx_data !== q_m[0]) begin errors++; $display("FAIL rnd_head %0d: got %h expected %h", i, tx_data, q_m[0]); end
      end
      tick();
    end
  endtask
  initial begin
    drive(0, 0, 32'h0, 0, 0, 1);
    tick();
    drive(0, 0, 32'h0, 0, 0, 1);
    tick();
    test_reset();
    test_ram();
    test_tx();
    test_overflow();
    test_counter();
    test_isolation();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
